// File: rtl/command_serializer_pkg.sv
// rtl/command_serializer_pkg.sv - shared command codes, field masks and serializer states
package command_serializer_pkg;

   localparam logic [7:0] COMMAND_WRITE_BLOCK_INSTR  = 8'h01;
   localparam logic [7:0] COMMAND_WRITE_BLOCK_REG    = 8'h02;
   localparam logic [7:0] COMMAND_UPDATE_BLOCK_REG   = 8'h03;
   localparam logic [7:0] COMMAND_ALLOC_DELAY        = 8'h04;
   localparam logic [7:0] COMMAND_SET_INPUT_GAIN     = 8'h05;
   localparam logic [7:0] COMMAND_SET_OUTPUT_GAIN    = 8'h06;
   localparam logic [7:0] COMMAND_COMMIT_REG_UPDATES = 8'h07;
   localparam logic [7:0] COMMAND_SWAP_PIPELINES     = 8'h10;
   localparam logic [7:0] COMMAND_RESET_PIPELINE     = 8'h11;

   // Opcode bit 3 selects the pipeline and does not change the frame layout.
   localparam logic [7:0] CMD_PIPE_SEL = 8'h08;

   localparam logic [4:0] CMD_FIELD_BLOCK = 5'b00001;
   localparam logic [4:0] CMD_FIELD_REG   = 5'b00010;
   localparam logic [4:0] CMD_FIELD_DATA  = 5'b00100;
   localparam logic [4:0] CMD_FIELD_INSTR = 5'b01000;
   localparam logic [4:0] CMD_FIELD_DELAY = 5'b10000;

   localparam int CMD_DELAY_BYTES = 4;

   // Field mask bit i corresponds to state encoding i+2.
   typedef enum logic [2:0] {
      SER_STATE_IDLE   = 3'd0,
      SER_STATE_OPCODE = 3'd1,
      SER_STATE_BLOCK  = 3'd2,
      SER_STATE_REG    = 3'd3,
      SER_STATE_DATA   = 3'd4,
      SER_STATE_INSTR  = 3'd5,
      SER_STATE_DELAY  = 3'd6
   } ser_state_t;

   function automatic ser_state_t next_field_state(input ser_state_t cur, input logic [4:0] mask);
      ser_state_t nxt;
      nxt = SER_STATE_IDLE;
      for (int i = 4; i >= 0; i--) begin
         if (mask[i] && ((i + 2) > int'(cur))) begin
            nxt = ser_state_t'(3'(i + 2));
         end
      end
      return nxt;
   endfunction

endpackage

// File: rtl/command_field_map.sv
// rtl/command_field_map.sv - opcode to frame field mask decoder
module command_field_map
   import command_serializer_pkg::*;
(
   input  logic [7:0] opcode,
   output logic [4:0] field_mask,
   output logic       unknown
);

   always_comb begin
      field_mask = 5'b00000;
      unknown    = 1'b0;
      case (opcode & ~CMD_PIPE_SEL)
         COMMAND_WRITE_BLOCK_INSTR:
            field_mask = CMD_FIELD_BLOCK | CMD_FIELD_INSTR;
         COMMAND_WRITE_BLOCK_REG, COMMAND_UPDATE_BLOCK_REG:
            field_mask = CMD_FIELD_BLOCK | CMD_FIELD_REG | CMD_FIELD_DATA;
         COMMAND_ALLOC_DELAY:
            field_mask = CMD_FIELD_DATA | CMD_FIELD_DELAY;
         COMMAND_SET_INPUT_GAIN, COMMAND_SET_OUTPUT_GAIN:
            field_mask = CMD_FIELD_DATA;
         COMMAND_COMMIT_REG_UPDATES, COMMAND_SWAP_PIPELINES, COMMAND_RESET_PIPELINE:
            field_mask = 5'b00000;
         default:
            unknown = 1'b1;
      endcase
   end

endmodule

// File: rtl/command_serializer.sv
// rtl/command_serializer.sv - parallel command word to control-unit byte frame transmitter
module command_serializer
   import command_serializer_pkg::*;
#(
   parameter int data_width     = 16,
   parameter int instr_width    = 32,
   parameter int timeout_cycles = 1024
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [7:0]              cmd_opcode,
   input  logic [7:0]              cmd_block,
   input  logic [7:0]              cmd_reg,
   input  logic [data_width-1:0]   cmd_data,
   input  logic [instr_width-1:0]  cmd_instr,
   input  logic [2*data_width-1:0] cmd_delay,
   output logic [7:0]              out_byte,
   output logic                    out_valid,
   input  logic                    out_next,
   output logic                    busy,
   output logic                    done,
   output logic                    timeout,
   output logic                    unknown_op
);

   localparam int DATA_BYTES  = data_width / 8;
   localparam int INSTR_BYTES = instr_width / 8;
   localparam int MAX_A       = (DATA_BYTES > INSTR_BYTES) ? DATA_BYTES : INSTR_BYTES;
   localparam int MAX_BYTES   = (MAX_A > CMD_DELAY_BYTES) ? MAX_A : CMD_DELAY_BYTES;
   localparam int CNT_W       = $clog2(MAX_BYTES) + 1;
   localparam int TO_W        = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;

   ser_state_t                state_q, state_d;
   logic [4:0]                mask_q, map_mask;
   logic                      map_unknown;
   logic [7:0]                op_q, block_q, reg_q;
   logic [data_width-1:0]     data_sr;
   logic [instr_width-1:0]    instr_sr;
   logic [2*data_width-1:0]   delay_sr;
   logic [CNT_W-1:0]          byte_cnt, field_len;
   logic [TO_W-1:0]           to_cnt;
   logic                      done_q, timeout_q, unknown_q, ready_q;
   logic                      accept, advance, last_byte, to_hit;

   command_field_map u_field_map (
      .opcode     (cmd_opcode),
      .field_mask (map_mask),
      .unknown    (map_unknown)
   );

   assign out_valid  = (state_q != SER_STATE_IDLE);
   assign busy       = out_valid;
   assign cmd_ready  = ready_q && (state_q == SER_STATE_IDLE);
   assign done       = done_q;
   assign timeout    = timeout_q;
   assign unknown_op = unknown_q;
   assign accept     = cmd_valid && cmd_ready;
   assign advance    = out_valid && out_next;
   assign last_byte  = (byte_cnt == field_len - CNT_W'(1));
   // A consumed byte always wins over a terminal timeout count in the same cycle.
   assign to_hit     = (timeout_cycles != 0) && out_valid && !out_next &&
                       (to_cnt == TO_W'(timeout_cycles - 1));

   always_comb begin
      field_len = CNT_W'(1);
      case (state_q)
         SER_STATE_DATA:  field_len = CNT_W'(DATA_BYTES);
         SER_STATE_INSTR: field_len = CNT_W'(INSTR_BYTES);
         SER_STATE_DELAY: field_len = CNT_W'(CMD_DELAY_BYTES);
         default:         field_len = CNT_W'(1);
      endcase
   end

   always_comb begin
      out_byte = 8'h00;
      case (state_q)
         SER_STATE_OPCODE: out_byte = op_q;
         SER_STATE_BLOCK:  out_byte = block_q;
         SER_STATE_REG:    out_byte = reg_q;
         SER_STATE_DATA:   out_byte = data_sr[data_width-1 -: 8];
         SER_STATE_INSTR:  out_byte = instr_sr[instr_width-1 -: 8];
         SER_STATE_DELAY:  out_byte = delay_sr[2*data_width-1 -: 8];
         default:          out_byte = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= SER_STATE_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (accept) begin
         state_d = SER_STATE_OPCODE;
      end else if (advance) begin
         if (last_byte) state_d = next_field_state(state_q, mask_q);
      end else if (to_hit) begin
         state_d = SER_STATE_IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mask_q    <= '0;
         op_q      <= '0;
         block_q   <= '0;
         reg_q     <= '0;
         data_sr   <= '0;
         instr_sr  <= '0;
         delay_sr  <= '0;
         byte_cnt  <= '0;
         to_cnt    <= '0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         unknown_q <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         ready_q   <= 1'b1;
         done_q    <= advance && last_byte && (state_d == SER_STATE_IDLE);
         timeout_q <= to_hit;
         unknown_q <= accept && map_unknown;
         if (accept) begin
            mask_q   <= map_mask;
            op_q     <= cmd_opcode;
            block_q  <= cmd_block;
            reg_q    <= cmd_reg;
            data_sr  <= cmd_data;
            instr_sr <= cmd_instr;
            delay_sr <= cmd_delay;
            byte_cnt <= '0;
            to_cnt   <= '0;
         end else if (advance) begin
            to_cnt   <= '0;
            byte_cnt <= last_byte ? '0 : byte_cnt + CNT_W'(1);
            case (state_q)
               SER_STATE_DATA:  data_sr  <= data_sr << 8;
               SER_STATE_INSTR: instr_sr <= instr_sr << 8;
               SER_STATE_DELAY: delay_sr <= delay_sr << 8;
               default: ;
            endcase
         end else if (out_valid) begin
            to_cnt <= to_cnt + TO_W'(1);
         end
      end
   end

endmodule

// File: doc/command_serializer.md
Name: command_serializer

Overview:
- Host-side transmitter for the control-unit byte protocol.
- Accepts one parallel command word per valid/ready handshake and emits its byte frame in exactly the order and length the control unit expects.
- Paces each byte on the control unit's `next` acknowledge.
- Sits between the host bridge / MCU command FIFO and the control unit's in_byte/in_ready/next port.

Parameters:
- data_width, 16, register/gain data width; must be a multiple of 8.
- instr_width, 32, block instruction width (`BLOCK_INSTR_WIDTH`); must be a multiple of 8.
- timeout_cycles, 1024, cycles without `next` before the frame is aborted; 0 disables the timeout.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command word valid
- cmd_ready  output  1  high only in IDLE
- cmd_opcode  input  8  command byte (`COMMAND_*`), passed through unchanged; bit 3 is the pipeline select
- cmd_block  input  8  block number
- cmd_reg  input  8  register number
- cmd_data  input  data_width  data field
- cmd_instr  input  instr_width  instruction field
- cmd_delay  input  2*data_width  delay-buffer init value
- out_byte  output  8  byte to the control unit (in_byte)
- out_valid  output  1  byte valid (in_ready)
- out_next  input  1  byte-consumed pulse (next)
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse after the last byte is consumed
- timeout  output  1  one-cycle pulse on abort
- unknown_op  output  1  one-cycle pulse when an unrecognised opcode is accepted

Behaviour:
- **Reset:** reset low asynchronously clears all outputs to 0 and forces IDLE. Any partial frame is discarded; the control unit must be reset alongside.
- **Frame order:** OPCODE → BLOCK → REG → DATA → INSTR → DELAY. Absent fields are skipped. Multi-byte fields go MSB first.
  - WRITE_BLOCK_INSTR: opcode, block, instr (instr_width/8 bytes).
  - WRITE_BLOCK_REG, UPDATE_BLOCK_REG: opcode, block, reg, data (data_width/8 bytes).
  - ALLOC_DELAY: opcode, data (data_width/8 bytes), delay (4 bytes).
  - SET_INPUT_GAIN, SET_OUTPUT_GAIN: opcode, data.
  - COMMIT_REG_UPDATES, SWAP_PIPELINES, RESET_PIPELINE: opcode only.
  - Any other opcode: opcode only, plus an unknown_op pulse on acceptance.
- **Accept:** when cmd_valid && cmd_ready at edge k, all fields are latched into shift registers and the field mask is registered. At edge k+1: out_valid=1, out_byte=opcode, busy=1, cmd_ready=0.
- **Advance:** on out_next && out_valid, out_byte updates at the next edge.
  - out_valid stays high between bytes; the control unit's wait_one masks the stale cycle.
  - out_next while out_valid=0 is ignored.
- **Last byte:** on out_next for the final byte, the next edge sets out_valid=0, busy=0, cmd_ready=1, and pulses done.
  - A new command may be accepted on the edge after done (minimum 1-cycle gap).
- **Timeout:** a counter clears on every byte presented and increments while out_valid && !out_next. When it reaches timeout_cycles-1:
  - the next edge drops out_valid, pulses timeout, and returns to IDLE;
  - done is not pulsed.
- **Field counters:** a byte counter per field runs from 0 to len-1, with len a constant from the shared package. A counter of at least $clog2(instr_width/8)+1 bits is required.
- **Simultaneous events:** timeout-terminal and out_next in the same cycle resolve as out_next (no timeout).
- **Block/reg values:** cmd_block and cmd_reg are sent as full bytes; the control unit truncates them.
- **State machine:** IDLE, OPCODE, BLOCK, REG, DATA, INSTR, DELAY. From each state the next state is the next field set in the mask, or IDLE after the last field.

Decomposition:
- Shared package (controller.vh) holds:
  - the `COMMAND_*` codes;
  - new `CMD_FIELD_BLOCK/REG/DATA/INSTR/DELAY` mask bits;
  - `CMD_DELAY_BYTES` = 4;
  - serializer state encodings `SER_STATE_*`.
- Sub-module command_field_map (combinational): opcode → 5-bit field mask and an unknown flag. The control unit's test bench reuses it.

Test Plan:
- WRITE_BLOCK_REG, block=0x05, reg=0x03, data=0x1234, next 1 cycle after each byte → bytes opcode,05,03,12,34; done on the edge after the 5th next; cmd_ready high the same edge.
- WRITE_BLOCK_INSTR, block=0x07, instr=0xDEADBEEF → opcode,07,DE,AD,BE,EF; no reg or data bytes emitted.
- ALLOC_DELAY, data=0x0100, delay=0x00012345 → opcode,01,00,00,01,23,45; connected to control_unit, alloc_delay pulses with buf_init_delay=0x00012345.
- SWAP_PIPELINES, then opcode 0xFF → single-byte frames; unknown_op pulses for 0xFF only; two done pulses.
- timeout_cycles=16, no next after the 2nd byte → timeout pulse 16 cycles after the byte is presented; out_valid=0; cmd_ready=1; no done.
- reset driven low mid-DATA → outputs 0 asynchronously; after release, a full WRITE_BLOCK_REG is transmitted correctly.
